hps_req_handshake_ctrl: RTL and testbench

- Sequences one FPGA compute job per HPS request using a 4-phase req/ack handshake.
- Input is the level-sensitive request bit driven by the HPS-side PIO output.
- Issues a one-cycle start pulse to the compute engine, waits for engine done (or timeout), then returns ack plus a latched result/status to HPS-readable PIO inputs.
- Sits between the Computer_System PIO ports and the string-art compute engine in the top level.

---
 rtl/hps_req_handshake_ctrl_if.sv | 26 ++
 rtl/hps_req_handshake_ctrl.sv | 85 ++++++++
 tb/tb_hps_req_handshake_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hps_req_handshake_ctrl_if.sv
// HPS-side PIO handshake signals and engine-side job signals of the request controller.
// The controller uses the slave modport; the HPS/engine side uses master.
interface hps_req_handshake_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic [DATA_W-1:0] arg_in;
  logic              eng_start;
  logic [DATA_W-1:0] eng_arg;
  logic              eng_done;
  logic [DATA_W-1:0] eng_result;
  logic              ack;
  logic [DATA_W-1:0] result;
  logic [1:0]        status;
  logic [15:0]       job_count;

  modport slave (
    input  req, arg_in, eng_done, eng_result,
    output eng_start, eng_arg, ack, result, status, job_count
  );

  modport master (
    output req, arg_in, eng_done, eng_result,
    input  eng_start, eng_arg, ack, result, status, job_count
  );
endinterface

// File: rtl/hps_req_handshake_ctrl.sv
// Runs one compute-engine job per HPS request level using a 4-phase req/ack handshake,
// with an optional engine timeout and a latched result/status for the HPS to read.
module hps_req_handshake_ctrl #(
  parameter int               DATA_W     = 32,
  parameter int               TMO_W      = 24,
  parameter logic [TMO_W-1:0] TMO_CYCLES = 24'd10000000
) (
  input  logic                    clk,
  input  logic                    reset,
  hps_req_handshake_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYCLES - TMO_W'(1);
  localparam bit               TMO_EN   = (TMO_CYCLES != '0);

  logic [1:0]        state_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic [DATA_W-1:0] eng_arg_q;
  logic [DATA_W-1:0] result_q;
  logic              tmo_flag_q;
  logic [15:0]       job_cnt_q;
  logic              tmo_hit;

  assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LAST);

  // Job sequencing: accept, start pulse, wait for done/timeout, hold ack until req drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tmo_cnt_q  <= '0;
      eng_arg_q  <= '0;
      result_q   <= '0;
      tmo_flag_q <= 1'b0;
      job_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            eng_arg_q  <= bus.arg_in;
            tmo_flag_q <= 1'b0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          tmo_cnt_q <= '0;
          state_q   <= S_BUSY;
        end
        S_BUSY: begin
          tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          // A done in the same cycle as the timeout takes priority
          if (bus.eng_done) begin
            result_q  <= bus.eng_result;
            job_cnt_q <= job_cnt_q + 16'd1;
            state_q   <= S_ACK;
          end else if (tmo_hit) begin
            result_q   <= '0;
            tmo_flag_q <= 1'b1;
            job_cnt_q  <= job_cnt_q + 16'd1;
            state_q    <= S_ACK;
          end
        end
        S_ACK: begin
          if (!bus.req) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // All outputs decode directly from flops, so req never reaches ack combinationally
  assign bus.eng_start = (state_q == S_START);
  assign bus.ack       = (state_q == S_ACK);
  assign bus.eng_arg   = eng_arg_q;
  assign bus.result    = result_q;
  assign bus.status    = {tmo_flag_q, (state_q != S_IDLE)};
  assign bus.job_count = job_cnt_q;

endmodule

// File: tb/tb_hps_req_handshake_ctrl.sv
// Directed bench for hps_req_handshake_ctrl: a per-cycle vector table for a basic job
// followed by hand-written timeout, tie, back-to-back, reset-abort and wrap sequences.
module tb_hps_req_handshake_ctrl;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hps_req_handshake_ctrl_if #(.DATA_W(DW)) bus ();

  hps_req_handshake_ctrl #(
    .DATA_W(DW), .TMO_W(24), .TMO_CYCLES(24'd16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic        req;
    logic [31:0] arg;
    logic        done;
    logic [31:0] res;
    logic        x_start;
    logic        x_ack;
    logic [1:0]  x_status;
    logic [31:0] x_result;
    logic [15:0] x_jc;
    logic [31:0] x_arg;
  } vec_t;

  vec_t tv[15];
  int   n_chk = 0;
  int   n_fail = 0;
  int   start_seen = 0;

  // Count start pulses mid-cycle, away from both clock edges used by the checks
  always @(posedge clk) begin
    #2;
    if (bus.eng_start === 1'b1) start_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req = 1'b0;
    bus.eng_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_start(input string nm);
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.eng_start;
    end
    chk(nm, 32'(got), 32'd1);
  endtask

  task automatic finish_job(input logic [31:0] r);
    @(negedge clk);
    bus.eng_done = 1'b1;
    bus.eng_result = r;
    @(negedge clk);
    bus.eng_done = 1'b0;
  endtask

  initial begin
    int s0;
    int c;
    bit got;

    reset = 1'b1;
    bus.req = 1'b0;
    bus.arg_in = '0;
    bus.eng_done = 1'b0;
    bus.eng_result = '0;

    // Basic job, cycle by cycle: outputs after the edge that samples each row's inputs
    for (int i = 0; i < 15; i++)
      tv[i] = '{req: 1'b1, arg: 32'h0, done: 1'b0, res: 32'h0, x_start: 1'b0, x_ack: 1'b0,
                x_status: 2'b01, x_result: 32'h0, x_jc: 16'd0, x_arg: 32'hA5};
    tv[0].arg = 32'h0000_00A5;
    tv[0].x_start = 1'b1;
    tv[1].arg = 32'h0000_0BAD;
    tv[10].done = 1'b1;
    tv[10].res = 32'h1234_5678;
    for (int i = 10; i < 15; i++) begin
      tv[i].x_result = 32'h1234_5678;
      tv[i].x_jc = 16'd1;
    end
    tv[10].x_ack = 1'b1;
    tv[11].x_ack = 1'b1;
    for (int i = 12; i < 15; i++) begin
      tv[i].req = 1'b0;
      tv[i].x_status = 2'b00;
    end
    tv[13].done = 1'b1;
    tv[13].res = 32'hDEAD_BEEF;
    tv[14].arg = 32'h0000_0077;

    repeat (2) @(negedge clk);
    chk("rst.start", 32'(bus.eng_start), 32'd0);
    chk("rst.ack", 32'(bus.ack), 32'd0);
    chk("rst.status", 32'(bus.status), 32'd0);
    chk("rst.result", bus.result, 32'd0);
    chk("rst.job_count", 32'(bus.job_count), 32'd0);
    chk("rst.eng_arg", bus.eng_arg, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.req = tv[i].req;
      bus.arg_in = tv[i].arg;
      bus.eng_done = tv[i].done;
      bus.eng_result = tv[i].res;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.start", i), 32'(bus.eng_start), 32'(tv[i].x_start));
      chk($sformatf("v%0d.ack", i), 32'(bus.ack), 32'(tv[i].x_ack));
      chk($sformatf("v%0d.status", i), 32'(bus.status), 32'(tv[i].x_status));
      chk($sformatf("v%0d.result", i), bus.result, tv[i].x_result);
      chk($sformatf("v%0d.job_count", i), 32'(bus.job_count), 32'(tv[i].x_jc));
      chk($sformatf("v%0d.eng_arg", i), bus.eng_arg, tv[i].x_arg);
    end
    @(negedge clk);
    bus.eng_done = 1'b0;

    // Timeout: no done, ack 17 cycles after the start pulse
    do_reset();
    bus.req = 1'b1;
    bus.arg_in = 32'h33;
    wait_start("tmo.start");
    c = 0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      c++;
      got = bus.ack;
    end
    chk("tmo.latency", 32'(c), 32'd17);
    chk("tmo.result", bus.result, 32'd0);
    chk("tmo.status", 32'(bus.status), 32'd3);
    chk("tmo.job_count", 32'(bus.job_count), 32'd1);
    bus.req = 1'b0;
    @(negedge clk);
    chk("tmo.ack_drop", 32'(bus.ack), 32'd0);
    chk("tmo.status_idle", 32'(bus.status), 32'd2);

    // Tie: done arrives on the same edge the timeout would fire
    do_reset();
    bus.req = 1'b1;
    wait_start("tie.start");
    repeat (16) @(negedge clk);
    chk("tie.ack_before", 32'(bus.ack), 32'd0);
    bus.eng_done = 1'b1;
    bus.eng_result = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.eng_done = 1'b0;
    chk("tie.ack", 32'(bus.ack), 32'd1);
    chk("tie.result", bus.result, 32'hFFFF_FFFF);
    chk("tie.status", 32'(bus.status), 32'd1);
    bus.req = 1'b0;
    @(negedge clk);

    // Back-to-back: req held through ack must not start a second job
    do_reset();
    s0 = start_seen;
    bus.req = 1'b1;
    bus.arg_in = 32'h11;
    wait_start("b2b.start1");
    finish_job(32'h0000_AAAA);
    chk("b2b.ack1", 32'(bus.ack), 32'd1);
    bus.arg_in = 32'h22;
    repeat (5) @(negedge clk);
    chk("b2b.ack_held", 32'(bus.ack), 32'd1);
    chk("b2b.no_restart", 32'(start_seen - s0), 32'd1);
    bus.req = 1'b0;
    @(negedge clk);
    chk("b2b.ack_drop", 32'(bus.ack), 32'd0);
    repeat (2) @(negedge clk);
    chk("b2b.idle_starts", 32'(start_seen - s0), 32'd1);
    bus.req = 1'b1;
    wait_start("b2b.start2");
    chk("b2b.arg2", bus.eng_arg, 32'h22);
    chk("b2b.two_starts", 32'(start_seen - s0), 32'd2);
    finish_job(32'h0000_BBBB);
    chk("b2b.job_count", 32'(bus.job_count), 32'd2);
    chk("b2b.result2", bus.result, 32'h0000_BBBB);
    bus.req = 1'b0;
    @(negedge clk);

    // Reset mid-BUSY clears everything at once, then a clean job follows
    bus.req = 1'b1;
    bus.arg_in = 32'h99;
    wait_start("abort.start");
    repeat (3) @(negedge clk);
    chk("abort.busy", 32'(bus.status), 32'd1);
    reset = 1'b1;
    bus.req = 1'b0;
    #1;
    chk("abort.ack", 32'(bus.ack), 32'd0);
    chk("abort.status", 32'(bus.status), 32'd0);
    chk("abort.job_count", 32'(bus.job_count), 32'd0);
    chk("abort.eng_arg", bus.eng_arg, 32'd0);
    chk("abort.result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    s0 = start_seen;
    repeat (2) @(negedge clk);
    chk("abort.no_start", 32'(start_seen - s0), 32'd0);
    bus.req = 1'b1;
    bus.arg_in = 32'h44;
    wait_start("abort.restart");
    chk("abort.arg", bus.eng_arg, 32'h44);
    finish_job(32'h0000_0555);
    chk("abort.job_count2", 32'(bus.job_count), 32'd1);
    chk("abort.result2", bus.result, 32'h0000_0555);
    bus.req = 1'b0;
    @(negedge clk);

    // Wrap: preload 65535 completed jobs, one more rolls the counter to zero
    force dut.job_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.job_cnt_q;
    @(negedge clk);
    chk("wrap.preload", 32'(bus.job_count), 32'h0000_FFFF);
    bus.req = 1'b1;
    wait_start("wrap.start");
    finish_job(32'h0000_0001);
    chk("wrap.job_count", 32'(bus.job_count), 32'd0);
    bus.req = 1'b0;
    @(negedge clk);
    chk("wrap.ack_drop", 32'(bus.ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
